// File: rtl/yadan_mem_arbiter.sv
// Three-master arbiter for the yadan single-port inst/data memory.
// Loader (m0) has priority; m1/m2 share round-robin and outrank m0 once starved.
module yadan_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,

  input  logic                m2_req,
  input  logic                m2_we,
  input  logic [ADDR_W-1:0]   m2_addr,
  input  logic [DATA_W-1:0]   m2_wdata,
  input  logic [DATA_W/8-1:0] m2_be,
  output logic                m2_gnt,
  output logic                m2_rvalid,
  output logic [DATA_W-1:0]   m2_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_M0   = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

  mem_cmd_t         cmd0, cmd1, cmd2, cmd_sel_c;
  owner_e           sel_c;
  owner_e           rsp_owner;
  logic             rsp_we;
  logic             rr_ptr;
  logic [CNT_W-1:0] starve1, starve2;
  logic             starved1_c, starved2_c;

  assign cmd0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
  assign cmd1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};
  assign cmd2 = '{we: m2_we, addr: m2_addr, wdata: m2_wdata, be: m2_be};

  assign starved1_c = m1_req && (starve1 == LIMIT);
  assign starved2_c = m2_req && (starve2 == LIMIT);

  // Grant selection: starved core > loader > round-robin core; nothing while in reset
  always_comb begin
    sel_c = OWN_NONE;
    if (!rst) begin
      sel_c = OWN_NONE;
    end else if (starved1_c && starved2_c) begin
      sel_c = rr_ptr ? OWN_M2 : OWN_M1;
    end else if (starved1_c) begin
      sel_c = OWN_M1;
    end else if (starved2_c) begin
      sel_c = OWN_M2;
    end else if (m0_req) begin
      sel_c = OWN_M0;
    end else if (m1_req && m2_req) begin
      sel_c = rr_ptr ? OWN_M2 : OWN_M1;
    end else if (m1_req) begin
      sel_c = OWN_M1;
    end else if (m2_req) begin
      sel_c = OWN_M2;
    end
  end

  assign m0_gnt = (sel_c == OWN_M0);
  assign m1_gnt = (sel_c == OWN_M1);
  assign m2_gnt = (sel_c == OWN_M2);

  // Memory command mux; all-zero when idle
  always_comb begin
    cmd_sel_c = '0;
    case (sel_c)
      OWN_M0:  cmd_sel_c = cmd0;
      OWN_M1:  cmd_sel_c = cmd1;
      OWN_M2:  cmd_sel_c = cmd2;
      default: cmd_sel_c = '0;
    endcase
  end

  assign mem_req   = (sel_c != OWN_NONE);
  assign mem_we    = cmd_sel_c.we;
  assign mem_addr  = cmd_sel_c.addr;
  assign mem_wdata = cmd_sel_c.wdata;
  assign mem_be    = cmd_sel_c.be;

  function automatic logic [CNT_W-1:0] starve_next(input logic             req,
                                                   input logic             gnt,
                                                   input logic [CNT_W-1:0] cnt);
    if (!req || gnt) begin
      return '0;
    end
    if (cnt >= LIMIT) begin
      return LIMIT;
    end
    return cnt + CNT_W'(1);
  endfunction

  // Arbitration state and one-cycle response tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= 1'b0;
      starve1   <= '0;
      starve2   <= '0;
      rsp_owner <= OWN_NONE;
      rsp_we    <= 1'b0;
    end else begin
      rsp_owner <= sel_c;
      rsp_we    <= cmd_sel_c.we;
      if (sel_c == OWN_M1) begin
        rr_ptr <= 1'b1;
      end else if (sel_c == OWN_M2) begin
        rr_ptr <= 1'b0;
      end
      starve1 <= starve_next(m1_req, m1_gnt, starve1);
      starve2 <= starve_next(m2_req, m2_gnt, starve2);
    end
  end

  assign m0_rvalid = (rsp_owner == OWN_M0);
  assign m1_rvalid = (rsp_owner == OWN_M1);
  assign m2_rvalid = (rsp_owner == OWN_M2);

  // Writes return zero data as their acknowledge
  assign m0_rdata = (m0_rvalid && !rsp_we) ? mem_rdata : '0;
  assign m1_rdata = (m1_rvalid && !rsp_we) ? mem_rdata : '0;
  assign m2_rdata = (m2_rvalid && !rsp_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_yadan_mem_arbiter.sv
// Bench for yadan_mem_arbiter: memory model, priority-rank reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_yadan_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned LIM = 8;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [BW-1:0] m0_be;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [BW-1:0] m1_be;
  logic          m2_req, m2_we, m2_gnt, m2_rvalid;
  logic [AW-1:0] m2_addr;
  logic [DW-1:0] m2_wdata, m2_rdata;
  logic [BW-1:0] m2_be;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  int n_chk  = 0;
  int n_pass = 0;

  yadan_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_be(m2_be),
    .m2_gnt(m2_gnt), .m2_rvalid(m2_rvalid), .m2_rdata(m2_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BW); b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Synchronous memory seen by the DUT; write cycles return junk so gating is visible
  logic [DW-1:0] mem_arr [64];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_req) begin
      if (mem_we) begin
        mem_arr[mem_addr[5:0]] <= merge(mem_arr[mem_addr[5:0]], mem_wdata, mem_be);
        mem_rdata <= 32'hBAD0_0000 | DW'(mem_addr[5:0]);
      end else begin
        mem_rdata <= mem_arr[mem_addr[5:0]];
      end
    end
  end

  // Winner by rank: starved core (0/1), loader (2), round-robin core (4/5); lowest wins
  function automatic int pick(input logic [2:0] req, input int s1, input int s2, input int rr);
    int best;
    int best_key;
    best = -1;
    best_key = 1000;
    for (int k = 0; k < 3; k++) begin
      int key;
      int cnt;
      key = 1000;
      if (req[k]) begin
        if (k == 0) key = 2;
        else begin
          cnt = (k == 1) ? s1 : s2;
          key = ((cnt == int'(LIM)) ? 0 : 4) + (((k - 1) == rr) ? 0 : 1);
        end
      end
      if (key < best_key) begin
        best_key = key;
        best = k;
      end
    end
    return best;
  endfunction

  logic [DW-1:0] ref_mem [64];
  logic          ref_init = 1'b0;
  int            m_rr, m_s1, m_s2, m_own, w;
  logic [DW-1:0] m_rdata;
  logic [2:0]    rq;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic [BW-1:0] e_be;

  // Reference model compared against the DUT on every falling edge
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (!rst) begin
      chk("rst_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(0));
      chk("rst_mem_ctl", 64'({mem_req, mem_we, mem_be}), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}), 64'(0));
      chk("rst_rdata", 64'(m0_rdata | m1_rdata | m2_rdata), 64'(0));
      m_rr = 0; m_s1 = 0; m_s2 = 0; m_own = -1; m_rdata = '0;
    end else begin
      rq = {m2_req, m1_req, m0_req};
      w  = pick(rq, m_s1, m_s2, m_rr);
      case (w)
        0:       begin e_we = m0_we; e_addr = m0_addr; e_wd = m0_wdata; e_be = m0_be; end
        1:       begin e_we = m1_we; e_addr = m1_addr; e_wd = m1_wdata; e_be = m1_be; end
        2:       begin e_we = m2_we; e_addr = m2_addr; e_wd = m2_wdata; e_be = m2_be; end
        default: begin e_we = 1'b0;  e_addr = '0;      e_wd = '0;       e_be = '0;    end
      endcase
      chk("gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(w < 0 ? 0 : (1 << w)));
      chk("mem_req", 64'(mem_req), 64'(w >= 0));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      chk("mem_be", 64'(mem_be), 64'(e_be));
      chk("rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}), 64'(m_own < 0 ? 0 : (1 << m_own)));
      chk("m0_rdata", 64'(m0_rdata), 64'(m_own == 0 ? m_rdata : '0));
      chk("m1_rdata", 64'(m1_rdata), 64'(m_own == 1 ? m_rdata : '0));
      chk("m2_rdata", 64'(m2_rdata), 64'(m_own == 2 ? m_rdata : '0));
      if (w >= 0) begin
        if (e_we) begin
          ref_mem[e_addr[5:0]] = merge(ref_mem[e_addr[5:0]], e_wd, e_be);
          m_rdata = '0;
        end else begin
          m_rdata = ref_mem[e_addr[5:0]];
        end
      end
      m_own = w;
      if (w == 1) m_rr = 1;
      else if (w == 2) m_rr = 0;
      m_s1 = (!rq[1] || w == 1) ? 0 : ((m_s1 < int'(LIM)) ? m_s1 + 1 : int'(LIM));
      m_s2 = (!rq[2] || w == 2) ? 0 : ((m_s2 < int'(LIM)) ? m_s2 + 1 : int'(LIM));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h1234_5678; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1;  m1_wdata = 32'h0;         m1_be = 4'h0;
    m2_req = 1'b1; m2_we = 1'b0; m2_addr = 32'h2;  m2_wdata = 32'h0;         m2_be = 4'h0;

    // Reset with every request raised, then idle release
    repeat (10) begin
      cyc(); look();
      chk("t1_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(0));
      chk("t1_mem_req", 64'(mem_req), 64'(0));
    end
    cyc();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
    repeat (3) begin
      look();
      chk("t1_idle_rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}), 64'(0));
      cyc();
    end

    // Round-robin between m1 and m2
    m1_req = 1'b1; m2_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      look();
      chk("t2_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'((c % 2 == 0) ? 3'b010 : 3'b100));
      if (c > 0) chk("t2_rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}),
                     64'((c % 2 == 0) ? 3'b100 : 3'b010));
      if (c % 2 == 1) chk("t2_m1_rdata", 64'(m1_rdata), 64'(init_word(1)));
      if (c > 0 && c % 2 == 0) chk("t2_m2_rdata", 64'(m2_rdata), 64'(init_word(2)));
      cyc();
    end
    m1_req = 1'b0; m2_req = 1'b0;
    cyc();

    // Loader priority with m1 starving until cycle 8
    m0_req = 1'b1; m1_addr = 32'h10; m1_req = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 9) m1_req = 1'b0;
      look();
      chk("t3_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'((c == 8) ? 3'b010 : 3'b001));
      if (c == 9) begin
        chk("t3_m1_rvalid", 64'(m1_rvalid), 64'(1));
        chk("t3_m1_rdata", 64'(m1_rdata), 64'(init_word(16)));
      end
      cyc();
    end
    m0_req = 1'b0;
    m2_addr = 32'h5; m2_req = 1'b1;
    look();
    chk("t3_lone_m2_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b100));
    cyc();
    m2_req = 1'b0;
    cyc();

    // Both core masters starve together
    m0_req = 1'b1; m1_addr = 32'h11; m1_req = 1'b1; m2_addr = 32'h12; m2_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 9)  m1_req = 1'b0;
      if (c == 10) m2_req = 1'b0;
      look();
      chk("t4_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}),
          64'((c == 8) ? 3'b010 : (c == 9) ? 3'b100 : 3'b001));
      if (c == 9)  chk("t4_m1_rdata", 64'(m1_rdata), 64'(init_word(17)));
      if (c == 10) chk("t4_m2_rdata", 64'(m2_rdata), 64'(init_word(18)));
      cyc();
    end
    m0_req = 1'b0;
    cyc();

    // Write then read back, full word and single byte
    for (int it = 0; it < 2; it++) begin
      m0_we = 1'b1; m0_addr = 32'h4;
      m0_wdata = (it == 0) ? 32'hDEAD_BEEF : 32'h0000_00AA;
      m0_be    = (it == 0) ? 4'b1111 : 4'b0001;
      m0_req = 1'b1;
      look();
      chk("t5_wr_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b001));
      cyc();
      m0_req = 1'b0; m2_we = 1'b0; m2_addr = 32'h4; m2_req = 1'b1;
      look();
      chk("t5_wr_ack", 64'(m0_rvalid), 64'(1));
      chk("t5_wr_rdata", 64'(m0_rdata), 64'(0));
      chk("t5_rd_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b100));
      cyc();
      m2_req = 1'b0;
      look();
      chk("t5_rd_rvalid", 64'(m2_rvalid), 64'(1));
      chk("t5_rd_rdata", 64'(m2_rdata), 64'((it == 0) ? 32'hDEAD_BEEF : 32'hDEAD_BEAA));
      cyc();
    end

    // Reset lands while an m1 read response is pending
    m1_we = 1'b0; m1_addr = 32'h3; m1_req = 1'b1;
    look();
    chk("t6_gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b010));
    cyc();
    rst = 1'b0; m1_req = 1'b0;
    look();
    chk("t6_m1_rvalid", 64'(m1_rvalid), 64'(0));
    chk("t6_m1_rdata", 64'(m1_rdata), 64'(0));
    cyc();
    cyc();
    rst = 1'b1;
    look();
    chk("t6_post_rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}), 64'(0));
    cyc();
    m1_addr = 32'h7; m2_addr = 32'h8; m1_req = 1'b1; m2_req = 1'b1;
    look();
    chk("t6_rr_first", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b010));
    cyc();
    m1_req = 1'b0;
    look();
    chk("t6_rr_second", 64'({m2_gnt, m1_gnt, m0_gnt}), 64'(3'b100));
    cyc();
    m2_req = 1'b0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
